// File: rtl/spin_quad_accum.sv
// Spinner / button rotation accumulator: merges HPS spinner deltas and frame-rate
// button steps into a signed pending count, then drains it one angle step per clock.
module spin_quad_accum #(
   parameter int ANGLE_W      = 4,
   parameter int DIV_SHIFT    = 2,
   parameter int SLOW_RATE    = 1,
   parameter int FAST_RATE    = 2,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               strobe,
   input  logic               minus,
   input  logic               plus,
   input  logic               fast,
   input  logic [8:0]         spin_in,
   output logic [ANGLE_W-1:0] angle,
   output logic               dir,
   output logic               step
);

   localparam int HW = $clog2(ACCEL_FRAMES + 1);
   localparam logic signed [13:0] QUANT = 14'(1 << DIV_SHIFT);
   localparam logic signed [13:0] PMAX  = 14'sd2047;
   localparam logic signed [13:0] PMIN  = -14'sd2047;

   logic signed [11:0] r_pending;
   logic [HW-1:0]      r_hold;
   logic               r_last_dir;
   logic               r_primed;
   logic               r_strobe_d;
   logic               r_tog_d;
   logic [ANGLE_W-1:0] r_angle;
   logic               r_dir;
   logic               r_step;

   logic               w_tick;
   logic               w_sample;
   logic signed [13:0] w_pend_ext;
   logic signed [13:0] w_spin_add;
   logic signed [13:0] w_dig_add;
   logic signed [13:0] w_drain;
   logic signed [13:0] w_rate;
   logic signed [13:0] w_sum;
   logic signed [11:0] w_pend_nxt;
   logic [HW-1:0]      w_hold_nxt;
   logic               w_last_nxt;

   assign w_tick     = strobe & ~r_strobe_d;
   assign w_sample   = r_primed & (spin_in[8] != r_tog_d);
   assign w_pend_ext = 14'(r_pending);

   always_comb begin
      w_spin_add = '0;
      if (w_sample) w_spin_add = 14'($signed(spin_in[7:0]));
   end

   // Rate doubling looks at the hold count before this frame's increment.
   always_comb begin
      w_dig_add  = '0;
      w_hold_nxt = r_hold;
      w_last_nxt = r_last_dir;
      w_rate     = fast ? 14'(FAST_RATE) : 14'(SLOW_RATE);
      if (r_hold == HW'(ACCEL_FRAMES)) w_rate = w_rate <<< 1;
      if (w_tick) begin
         if (plus ^ minus) begin
            w_last_nxt = plus;
            if ((plus != r_last_dir) || (r_hold == '0))
               w_hold_nxt = HW'(1);
            else if (r_hold < HW'(ACCEL_FRAMES))
               w_hold_nxt = r_hold + HW'(1);
            w_dig_add = plus ? (w_rate <<< DIV_SHIFT) : -(w_rate <<< DIV_SHIFT);
         end else begin
            w_hold_nxt = '0;
         end
      end
   end

   always_comb begin
      w_drain = '0;
      if (w_pend_ext >= QUANT)       w_drain = QUANT;
      else if (w_pend_ext <= -QUANT) w_drain = -QUANT;
   end

   always_comb begin
      w_sum = w_pend_ext + w_spin_add + w_dig_add - w_drain;
      if (w_sum > PMAX)      w_pend_nxt = 12'(PMAX);
      else if (w_sum < PMIN) w_pend_nxt = 12'(PMIN);
      else                   w_pend_nxt = 12'(w_sum);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pending  <= '0;
         r_hold     <= '0;
         r_last_dir <= 1'b0;
         r_primed   <= 1'b0;
         r_strobe_d <= 1'b0;
         r_tog_d    <= 1'b0;
         r_angle    <= '0;
         r_dir      <= 1'b0;
         r_step     <= 1'b0;
      end else begin
         r_strobe_d <= strobe;
         r_pending  <= w_pend_nxt;
         r_hold     <= w_hold_nxt;
         r_last_dir <= w_last_nxt;
         if (!r_primed) begin
            r_primed <= 1'b1;
            r_tog_d  <= spin_in[8];
         end else if (w_sample) begin
            r_tog_d <= spin_in[8];
         end
         if (w_pend_ext >= QUANT) begin
            r_angle <= r_angle + 1'b1;
            r_dir   <= 1'b1;
            r_step  <= 1'b1;
         end else if (w_pend_ext <= -QUANT) begin
            r_angle <= r_angle - 1'b1;
            r_dir   <= 1'b0;
            r_step  <= 1'b1;
         end else begin
            r_step <= 1'b0;
         end
      end
   end

   assign angle = r_angle;
   assign dir   = r_dir;
   assign step  = r_step;

endmodule

// File: tb/tb_spin_quad_accum.sv
// Bench for spin_quad_accum: directed scenarios plus random traffic, all checked
// every cycle against an integer-arithmetic reference model.
module tb_spin_quad_accum;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       strobe  = 1'b0;
   logic       minus   = 1'b0;
   logic       plus    = 1'b0;
   logic       fast    = 1'b0;
   logic [8:0] spin_in = '0;
   logic [3:0] angle;
   logic       dir;
   logic       step;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spin_quad_accum #(
      .ANGLE_W(4), .DIV_SHIFT(2), .SLOW_RATE(1), .FAST_RATE(2), .ACCEL_FRAMES(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .strobe(strobe), .minus(minus), .plus(plus),
      .fast(fast), .spin_in(spin_in), .angle(angle), .dir(dir), .step(step)
   );

   // Reference model state (plain integers).
   int m_angle, m_dir, m_step, m_pend, m_hold, m_lastd, m_primed, m_sd, m_tog;
   bit m_valid = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int  add_s, add_d, drain, rate, pre;
      byte delta;
      bit  tick;
      if (!reset_n) begin
         m_angle = 0; m_dir = 0; m_step = 0; m_pend = 0; m_hold = 0;
         m_lastd = 0; m_primed = 0; m_sd = 0; m_tog = 0; m_valid = 1;
      end else begin
         tick = strobe && !m_sd;
         m_sd = strobe;
         add_s = 0;
         if (!m_primed) begin
            m_tog = spin_in[8]; m_primed = 1;
         end else if (spin_in[8] != m_tog) begin
            delta = spin_in[7:0];
            add_s = delta;
            m_tog = spin_in[8];
         end
         add_d = 0;
         if (tick) begin
            if (plus != minus) begin
               pre = m_hold;
               if (plus != m_lastd || m_hold == 0) m_hold = 1;
               else if (m_hold < 8) m_hold = m_hold + 1;
               rate = fast ? 2 : 1;
               if (pre == 8) rate = rate * 2;
               add_d = plus ? rate * 4 : -rate * 4;
               m_lastd = plus;
            end else begin
               m_hold = 0;
            end
         end
         drain = 0;
         if (m_pend >= 4) begin
            drain = 4; m_angle = (m_angle + 1) % 16; m_dir = 1; m_step = 1;
         end else if (m_pend <= -4) begin
            drain = -4; m_angle = (m_angle + 15) % 16; m_dir = 0; m_step = 1;
         end else begin
            m_step = 0;
         end
         m_pend = m_pend + add_s + add_d - drain;
         if (m_pend > 2047) m_pend = 2047;
         if (m_pend < -2047) m_pend = -2047;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("angle", int'(angle), m_angle);
         check("dir", int'(dir), m_dir);
         check("step", int'(step), m_step);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spin(input int d);
      spin_in = {~spin_in[8], 8'(d)};
      cyc(1);
   endtask

   task automatic frame();
      strobe = 1'b1; cyc(2);
      strobe = 1'b0; cyc(4);
   endtask

   initial begin
      cyc(3);
      check("rst_angle", int'(angle), 0);
      check("rst_step", int'(step), 0);
      check("rst_dir", int'(dir), 0);
      reset_n = 1'b1;
      cyc(3);

      // +8 in one sample: two consecutive steps
      spin(8);
      check("s8_wait", int'(step), 0);
      cyc(1);
      check("s8_a1", int'(angle), 1);
      check("s8_st1", int'(step), 1);
      cyc(1);
      check("s8_a2", int'(angle), 2);
      check("s8_st2", int'(step), 1);
      cyc(2);
      check("s8_pend", m_pend, 0);
      check("s8_dir", int'(dir), 1);

      // Sub-step residual accumulates across samples
      spin(3); cyc(3);
      check("s3_nostep", int'(angle), 2);
      spin(3); cyc(3);
      check("s3_angle", int'(angle), 3);
      check("s3_resid", m_pend, 2);

      // Held plus: 8 slow frames, then doubled rate
      frame();
      plus = 1'b1;
      repeat (10) frame();
      check("hold10", int'(angle), 15);
      repeat (2) frame();
      check("hold12_wrap", int'(angle), 3);

      plus = 1'b0; frame();
      plus = 1'b1; minus = 1'b1;
      repeat (5) frame();
      check("both_held", int'(angle), 3);
      check("both_hold0", m_hold, 0);
      minus = 1'b0; frame();
      check("release", int'(angle), 4);
      check("release_hold", m_hold, 1);
      plus = 1'b0; frame();

      // Large negative burst clamps, then reset mid-drain
      repeat (20) spin(-128);
      check("clamp", m_pend, -2047);
      cyc(50);
      check("drain_step", int'(step), 1);
      check("drain_dir", int'(dir), 0);
      reset_n = 1'b0; cyc(1);
      check("mid_rst_angle", int'(angle), 0);
      check("mid_rst_step", int'(step), 0);
      reset_n = 1'b1; cyc(3);

      // Spinner +4 and minus tick in the same cycle cancel
      minus = 1'b1; strobe = 1'b1;
      spin(4);
      strobe = 1'b0; cyc(5);
      check("cancel_angle", int'(angle), 0);
      check("cancel_pend", m_pend, 0);
      minus = 1'b0; cyc(2);

      // Random traffic
      repeat (4000) begin
         reset_n = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 7) == 0) strobe = ~strobe;
         if ($urandom_range(0, 199) == 0) {plus, minus, fast} = 3'($urandom);
         if ($urandom_range(0, 5) == 0) spin_in = {~spin_in[8], 8'($urandom)};
         cyc(1);
      end
      reset_n = 1'b1;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
